ddr2_read_data_path: RTL and testbench

- Read-direction counterpart to the DDR2 write data path.
- Takes rise/fall read data already captured by the IOBs, calibrates read latency during the controller's dummy-read phase, then tags valid beats and assembles them into 2*DATA_WIDTH words.
- Buffers those words in a small FIFO toward the user read interface.
- Sits between the IOB capture registers and the user read port, in the clk domain.

---
 rtl/ddr2_rd_pkg.sv | 27 ++
 rtl/ddr2_rd_fifo.sv | 61 ++++++
 rtl/ddr2_read_data_path.sv | 206 ++++++++++++++++++++
 tb/tb_ddr2_read_data_path.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_rd_pkg.sv
// Shared definitions for the DDR2 read data path: calibration state
// encoding, the dummy-read pattern and the latency counter width.
package ddr2_rd_pkg;

  // Latency, beat and fail counters are all this wide and saturate at max.
  localparam int CAL_LAT_W = 4;

  typedef enum logic [2:0] {
    CAL_IDLE  = 3'd0,
    CAL_WAIT  = 3'd1,
    CAL_MEAS  = 3'd2,
    CAL_CHECK = 3'd3,
    CAL_DONE  = 3'd4,
    CAL_ERR   = 3'd5
  } cal_state_t;

  // Dummy-read pattern: rise beat all ones, fall beat all zeros.
  // Sized generously; the top slices them down to DATA_WIDTH.
  localparam logic [127:0] CAL_PATTERN_RISE = '1;
  localparam logic [127:0] CAL_PATTERN_FALL = '0;

  // Saturating increment for the 4-bit counters.
  function automatic logic [CAL_LAT_W-1:0] sat_inc(input logic [CAL_LAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ddr2_rd_fifo.sv
// Small synchronous FIFO toward the user read port. The head word is read
// combinationally from registered storage; when empty the output holds the
// most recently popped word. A push into a full FIFO that is not popping in
// the same cycle is dropped and flagged on overflow for one cycle.
module ddr2_rd_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [WIDTH-1:0] last_reg;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && full && !do_pop;
  assign head_data = empty ? last_reg : mem[rd_ptr_reg[AW-1:0]];

  // Storage array, no reset so it maps onto plain RAM/LUT storage.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  // Pointers and the hold register that keeps the last popped word visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      last_reg   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        last_reg   <= mem[rd_ptr_reg[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/ddr2_read_data_path.sv
// DDR2 read data path: calibrates read latency from dummy reads, then uses
// a ctrl_rden delay line tapped at the calibrated latency to push captured
// {fall,rise} beats into the output FIFO.
// Optional macro RD_LAT_OVERRIDE_EN adds a debug latency override that also
// forces the normal path on regardless of calibration state.
module ddr2_read_data_path
  import ddr2_rd_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int BURST_LEN   = 4,
  parameter int MAX_RD_LAT  = 15,
  parameter int FIFO_DEPTH  = 8,
  parameter int CAL_RETRIES = 4
) (
  input  logic                    clk,
  input  logic                    reset0_n,
  input  logic                    ctrl_dummyread_start,
  input  logic                    ctrl_rden,
  input  logic [DATA_WIDTH-1:0]   rd_data_rise,
  input  logic [DATA_WIDTH-1:0]   rd_data_fall,
  input  logic                    rd_data_ready,
`ifdef RD_LAT_OVERRIDE_EN
  input  logic                    dbg_rd_lat_ovr_en,
  input  logic [3:0]              dbg_rd_lat_ovr,
`endif
  output logic                    rd_data_valid,
  output logic [2*DATA_WIDTH-1:0] rd_data,
  output logic                    rd_cal_done,
  output logic                    rd_cal_err,
  output logic [3:0]              rd_lat,
  output logic                    rd_overflow
);

  localparam logic [CAL_LAT_W-1:0] MAX_LAT_C   = CAL_LAT_W'(MAX_RD_LAT);
  localparam logic [CAL_LAT_W-1:0] RETRY_LIM   = CAL_LAT_W'(CAL_RETRIES);
  localparam logic [CAL_LAT_W-1:0] BEAT_RELOAD = CAL_LAT_W'(BURST_LEN / 2 - 1);

  cal_state_t             state_reg, state_next;
  logic [CAL_LAT_W-1:0]   cnt_reg, cnt_next;
  logic [CAL_LAT_W-1:0]   meas_reg, meas_next;
  logic [CAL_LAT_W-1:0]   stored_reg, stored_next;
  logic                   stored_vld_reg, stored_vld_next;
  logic [CAL_LAT_W-1:0]   fail_reg, fail_next;
  logic [CAL_LAT_W-1:0]   lat_reg, lat_next;
  logic [CAL_LAT_W-1:0]   fail_inc;
  logic                   start_d_reg;
  logic                   start_rise;
  logic                   pattern_hit;

  logic [MAX_RD_LAT:1]    dl_reg;
  logic [MAX_RD_LAT:0]    dl_vec;
  logic [CAL_LAT_W-1:0]   beat_cnt_reg, beat_cnt_next;
  logic [CAL_LAT_W-1:0]   tap_sel;
  logic                   path_en;
  logic                   tap_hit;
  logic                   push;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_ovf;
  logic                   overflow_reg;

  assign start_rise  = ctrl_dummyread_start && !start_d_reg;
  assign pattern_hit = (rd_data_rise == CAL_PATTERN_RISE[DATA_WIDTH-1:0]) &&
                       (rd_data_fall == CAL_PATTERN_FALL[DATA_WIDTH-1:0]);
  assign fail_inc    = sat_inc(fail_reg);

  assign rd_cal_done = (state_reg == CAL_DONE);
  assign rd_cal_err  = (state_reg == CAL_ERR);
  assign rd_lat      = rd_cal_done ? lat_reg : '0;

  // Calibration state and measurement registers.
  always_ff @(posedge clk or negedge reset0_n) begin
    if (!reset0_n) begin
      state_reg      <= CAL_IDLE;
      cnt_reg        <= '0;
      meas_reg       <= '0;
      stored_reg     <= '0;
      stored_vld_reg <= 1'b0;
      fail_reg       <= '0;
      lat_reg        <= '0;
      start_d_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      meas_reg       <= meas_next;
      stored_reg     <= stored_next;
      stored_vld_reg <= stored_vld_next;
      fail_reg       <= fail_next;
      lat_reg        <= lat_next;
      start_d_reg    <= ctrl_dummyread_start;
    end
  end

  // Calibration next state: measure, compare two runs, count failures.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    meas_next       = meas_reg;
    stored_next     = stored_reg;
    stored_vld_next = stored_vld_reg;
    fail_next       = fail_reg;
    lat_next        = lat_reg;
    if (start_rise) begin
      state_next      = CAL_WAIT;
      fail_next       = '0;
      stored_next     = '0;
      stored_vld_next = 1'b0;
    end else begin
      case (state_reg)
        CAL_WAIT: begin
          if (ctrl_rden) begin
            state_next = CAL_MEAS;
            cnt_next   = 4'd1;
          end
        end
        CAL_MEAS: begin
          if (pattern_hit) begin
            meas_next  = cnt_reg;
            state_next = CAL_CHECK;
          end else if (cnt_reg >= MAX_LAT_C) begin
            fail_next  = fail_inc;
            state_next = (fail_inc >= RETRY_LIM) ? CAL_ERR : CAL_WAIT;
          end else begin
            cnt_next = sat_inc(cnt_reg);
          end
        end
        CAL_CHECK: begin
          if (!stored_vld_reg) begin
            stored_next     = meas_reg;
            stored_vld_next = 1'b1;
            state_next      = CAL_WAIT;
          end else if (meas_reg == stored_reg) begin
            lat_next   = meas_reg;
            state_next = CAL_DONE;
          end else begin
            fail_next       = fail_inc;
            stored_next     = '0;
            stored_vld_next = 1'b0;
            state_next      = (fail_inc >= RETRY_LIM) ? CAL_ERR : CAL_WAIT;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RD_LAT_OVERRIDE_EN
  assign tap_sel = dbg_rd_lat_ovr_en ? dbg_rd_lat_ovr : lat_reg;
  assign path_en = dbg_rd_lat_ovr_en || (state_reg == CAL_DONE);
`else
  assign tap_sel = lat_reg;
  assign path_en = (state_reg == CAL_DONE);
`endif

  // Tap 0 is ctrl_rden itself; tap k is ctrl_rden delayed by k cycles.
  assign dl_vec  = {dl_reg, ctrl_rden};
  assign tap_hit = path_en && dl_vec[tap_sel];
  assign push    = path_en && (tap_hit || (beat_cnt_reg != '0));

  // Beat window: a tap hit pushes now and reloads the remaining-beat count,
  // so back-to-back reads produce one continuous push window.
  always_comb begin
    beat_cnt_next = beat_cnt_reg;
    if (!path_en) begin
      beat_cnt_next = '0;
    end else if (tap_hit) begin
      beat_cnt_next = BEAT_RELOAD;
    end else if (beat_cnt_reg != '0) begin
      beat_cnt_next = beat_cnt_reg - 1'b1;
    end
  end

  // Command delay line, beat counter and sticky overflow flag.
  always_ff @(posedge clk or negedge reset0_n) begin
    if (!reset0_n) begin
      dl_reg       <= '0;
      beat_cnt_reg <= '0;
      overflow_reg <= 1'b0;
    end else begin
      dl_reg       <= dl_vec[MAX_RD_LAT-1:0];
      beat_cnt_reg <= beat_cnt_next;
      if (fifo_ovf) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign rd_overflow   = overflow_reg;
  assign rd_data_valid = !fifo_empty;

  ddr2_rd_fifo #(
    .WIDTH (2 * DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset0_n),
    .push      (push),
    .push_data ({rd_data_fall, rd_data_rise}),
    .pop       (rd_data_valid && rd_data_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_data (rd_data),
    .overflow  (fifo_ovf)
  );

endmodule

// File: tb/tb_ddr2_read_data_path.sv
// Directed bench for ddr2_read_data_path: stimulus pushes expected words
// into a queue, a monitor pops and compares whenever a word is accepted.
module tb_ddr2_read_data_path;

  logic         clk = 1'b0;
  logic         reset0_n;
  logic         ctrl_dummyread_start;
  logic         ctrl_rden;
  logic [63:0]  rd_data_rise;
  logic [63:0]  rd_data_fall;
  logic         rd_data_ready;
  logic         rd_data_valid;
  logic [127:0] rd_data;
  logic         rd_cal_done;
  logic         rd_cal_err;
  logic [3:0]   rd_lat;
  logic         rd_overflow;

  logic [127:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [127:0] last_word = '0;
  bit           exp_ovf = 1'b0;

  ddr2_read_data_path dut (
    .clk                  (clk),
    .reset0_n             (reset0_n),
    .ctrl_dummyread_start (ctrl_dummyread_start),
    .ctrl_rden            (ctrl_rden),
    .rd_data_rise         (rd_data_rise),
    .rd_data_fall         (rd_data_fall),
    .rd_data_ready        (rd_data_ready),
`ifdef RD_LAT_OVERRIDE_EN
    .dbg_rd_lat_ovr_en    (1'b0),
    .dbg_rd_lat_ovr       (4'd0),
`endif
    .rd_data_valid        (rd_data_valid),
    .rd_data              (rd_data),
    .rd_cal_done          (rd_cal_done),
    .rd_cal_err           (rd_cal_err),
    .rd_lat               (rd_lat),
    .rd_overflow          (rd_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mkword(input int idx);
    logic [31:0] r;
    logic [31:0] f;
    r = 32'hAAAA0000 + 32'(idx);
    f = 32'hBBBB0000 + 32'(idx);
    return {f, f, r, r};
  endfunction

  // Monitor: one comparison per accepted word.
  initial begin
    logic [127:0] w;
    forever begin
      @(negedge clk);
      if (reset0_n === 1'b1 && rd_data_valid === 1'b1 && rd_data_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got %h expected none", rd_data);
        end else begin
          w = exp_q.pop_front();
          if (rd_data !== w) begin
            errors++;
            $display("FAIL rd_word: got %h expected %h", rd_data, w);
          end else begin
            $display("word ok %h", rd_data);
          end
          last_word = w;
        end
      end
    end
  end

  task automatic restart_cal();
    ctrl_dummyread_start = 1'b0;
    tick();
    ctrl_dummyread_start = 1'b1;
    tick();
  endtask

  // One dummy read; pattern returned at latency lat if pat is set.
  task automatic cal_burst(input int lat, input bit pat);
    for (int c = 0; c < lat + 22; c++) begin
      ctrl_rden    = (c == 0);
      rd_data_rise = '0;
      rd_data_fall = '0;
      if (pat && (c == lat || c == lat + 1)) begin
        rd_data_rise = '1;
      end
      tick();
    end
    ctrl_rden = 1'b0;
    $display("cal burst lat=%0d pat=%0d -> done=%0d err=%0d lat=%0d", lat, pat, rd_cal_done, rd_cal_err, rd_lat);
  endtask

  // nb reads spaced gap cycles apart, beats returned at latency lat.
  task automatic run_bursts(input int nb, input int gap, input int lat, input int base,
                            input bit ready_at_beats, input bit expect_push);
    int k;
    int j;
    logic [127:0] w;
    for (int c = 0; c < (nb - 1) * gap + lat + 4; c++) begin
      ctrl_rden    = ((c % gap) == 0) && ((c / gap) < nb);
      rd_data_rise = '0;
      rd_data_fall = '0;
      if (c >= lat) begin
        k = (c - lat) / gap;
        j = (c - lat) % gap;
        if (k < nb && j < 2) begin
          w = mkword(base + 2 * k + j);
          rd_data_rise = w[63:0];
          rd_data_fall = w[127:64];
          if (ready_at_beats) rd_data_ready = 1'b1;
          if (expect_push) begin
            if (exp_q.size() < 8 || (rd_data_ready && exp_q.size() > 0)) exp_q.push_back(w);
            else exp_ovf = 1'b1;
          end
        end
      end
      tick();
    end
    ctrl_rden    = 1'b0;
    rd_data_rise = '0;
    rd_data_fall = '0;
    $display("bursts nb=%0d gap=%0d base=%0d queued=%0d", nb, gap, base, exp_q.size());
  endtask

  initial begin
    logic [127:0] wa;
    logic [127:0] wb;
    logic [63:0]  a_r, a_f, b_r, b_f;
    int seen;
    reset0_n             = 1'b0;
    ctrl_dummyread_start = 1'b0;
    ctrl_rden            = 1'b0;
    rd_data_rise         = '0;
    rd_data_fall         = '0;
    rd_data_ready        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", rd_data_valid, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_done", rd_cal_done, 0);
    chk("rst_err", rd_cal_err, 0);
    chk("rst_lat", rd_lat, 0);
    chk("rst_ovf", rd_overflow, 0);
    reset0_n = 1'b1;
    tick();

    // Two matching measurements at L=5.
    restart_cal();
    cal_burst(5, 1);
    chk("cal5_first_not_done", rd_cal_done, 0);
    cal_burst(5, 1);
    chk("cal5_done", rd_cal_done, 1);
    chk("cal5_lat", rd_lat, 5);
    chk("cal5_err", rd_cal_err, 0);

    // 5 then 6 mismatch, then 6 and 6.
    restart_cal();
    chk("restart_clears_done", rd_cal_done, 0);
    cal_burst(5, 1);
    cal_burst(6, 1);
    chk("mismatch_not_done", rd_cal_done, 0);
    chk("mismatch_no_err", rd_cal_err, 0);
    cal_burst(6, 1);
    cal_burst(6, 1);
    chk("cal6_done", rd_cal_done, 1);
    chk("cal6_lat", rd_lat, 6);
    chk("cal6_err", rd_cal_err, 0);

    // Pattern never returned: four timeouts -> error.
    restart_cal();
    for (int i = 0; i < 3; i++) cal_burst(5, 0);
    chk("three_fails_no_err", rd_cal_err, 0);
    cal_burst(5, 0);
    chk("calerr_err", rd_cal_err, 1);
    chk("calerr_lat", rd_lat, 0);
    chk("calerr_done", rd_cal_done, 0);
    run_bursts(2, 4, 5, 50, 0, 0);
    chk("calerr_no_push", rd_data_valid, 0);

    // Recalibrate at 5, then first-word timing.
    restart_cal();
    cal_burst(5, 1);
    cal_burst(5, 1);
    chk("recal_lat", rd_lat, 5);
    a_r = {16{4'hA}};
    a_f = {16{4'hC}};
    b_r = {16{4'hB}};
    b_f = {16{4'hD}};
    wa  = {a_f, a_r};
    wb  = {b_f, b_r};
    ctrl_rden = 1'b1;
    tick();
    ctrl_rden = 1'b0;
    repeat (4) tick();
    rd_data_rise = a_r;
    rd_data_fall = a_f;
    exp_q.push_back(wa);
    chk("valid_at_t5", rd_data_valid, 0);
    tick();
    rd_data_rise = b_r;
    rd_data_fall = b_f;
    exp_q.push_back(wb);
    chk("valid_at_t6", rd_data_valid, 1);
    tick();
    rd_data_rise = '0;
    rd_data_fall = '0;
    repeat (5) tick();
    chk("empty_after_drain", rd_data_valid, 0);
    chk("hold_last_word", rd_data, wb);

    // Back-to-back reads concatenate windows.
    run_bursts(3, 2, 5, 0, 0, 1);
    repeat (8) tick();
    chk("b2b_drained", rd_data_valid, 0);

    // Fill FIFO, then push+pop while full.
    rd_data_ready = 1'b0;
    run_bursts(4, 4, 5, 100, 0, 1);
    chk("full_valid", rd_data_valid, 1);
    chk("full_no_ovf", rd_overflow, 0);
    run_bursts(1, 4, 5, 200, 1, 1);
    chk("pushpop_full_no_ovf", rd_overflow, 0);
    repeat (14) tick();
    chk("pushpop_drained", rd_data_valid, 0);

    // Overflow: 10 words into 8 entries.
    rd_data_ready = 1'b0;
    exp_ovf = 1'b0;
    run_bursts(5, 2, 5, 300, 0, 1);
    chk("ovf_set", rd_overflow, 128'(exp_ovf));
    chk("ovf_valid", rd_data_valid, 1);
    rd_data_ready = 1'b1;
    repeat (12) tick();
    chk("ovf_drained", rd_data_valid, 0);
    chk("ovf_sticky", rd_overflow, 1);

    // Reset mid-burst.
    rd_data_ready = 1'b0;
    ctrl_rden = 1'b1;
    tick();
    ctrl_rden = 1'b0;
    repeat (4) tick();
    rd_data_rise = a_r;
    rd_data_fall = a_f;
    exp_q.push_back(wa);
    tick();
    chk("pre_reset_valid", rd_data_valid, 1);
    reset0_n = 1'b0;
    #1;
    exp_q.delete();
    chk("midrst_valid", rd_data_valid, 0);
    chk("midrst_data", rd_data, 0);
    chk("midrst_done", rd_cal_done, 0);
    chk("midrst_lat", rd_lat, 0);
    chk("midrst_err", rd_cal_err, 0);
    chk("midrst_ovf", rd_overflow, 0);
    rd_data_ready = 1'b1;
    tick();
    tick();
    reset0_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      ctrl_rden = ((i % 3) == 0);
      tick();
      if (rd_data_valid) seen++;
    end
    ctrl_rden = 1'b0;
    chk("no_stale_words", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
